multicycle_datapath_p: RTL and testbench
========================================

Name: multicycle_datapath_p

Overview:
- Parametrised successor to the 8-bit multicycle MIPS-subset datapath.
- Generalised to data/PC width WIDTH (8/16/32) and register-file depth 2^REGBITS.
- Adds an autonomous instruction-fetch sequencer. It assembles the 32-bit instruction from 32/WIDTH memory beats over a req/ack handshake, replacing the controller-driven per-byte irwrite enables.
- Sits between the multicycle controller and the unified memory.

Parameters:
- WIDTH, 8, datapath/PC/memory-port width; legal values 8, 16, 32.
- REGBITS, 3, register address width; 2^REGBITS registers, 1..5.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- fetch_start  in  1  request an instruction fetch at the current PC.
- data_req  in  1  controller data-memory access request (load/store).
- alusrca  in  1  0: A register, 1: PC.
- alusrcb  in  2  00: B register, 01: constant 4, 10: imm, 11: imm<<2.
- alucontrol  in  3  000 and, 001 or, 010 add, 110 sub, 111 slt.
- iord  in  1  data address: 0 aluout, 1 PC.
- memtoreg  in  1  0: MDR, 1: aluout.
- regdst  in  1  write address: 0 instr[16+:REGBITS], 1 instr[11+:REGBITS].
- regwrite  in  1  register-file write enable.
- pcen  in  1  PC load enable.
- pcsource  in  2  00 aluresult, 01 aluout, 10 jump {instr[25:0],2'b00}[WIDTH-1:0], 11 hold PC.
- mem_rdata  in  WIDTH  memory read data, valid when mem_ack.
- mem_ack  in  1  memory accepts/completes the current beat.
- mem_req  out  1  memory request.
- adr  out  WIDTH  memory byte address.
- writedata  out  WIDTH  B register (store data).
- instr  out  32  instruction register.
- instr_valid  out  1  one-cycle pulse: instr complete.
- fetch_busy  out  1  high while the sequencer is not IDLE.
- zero  out  1  aluresult == 0.

Behaviour:
- All state updates on the rising edge of clk. reset is synchronous and takes priority over all other inputs.
- Reset values:
  - PC, A, B, aluout, MDR, instr, fetch_base and beat counter all 0.
  - All registers cleared to 0.
  - FSM in IDLE; instr_valid 0.
  - mem_req equals data_req (0 if data_req is low).
- Derived constants:
  - BEATS = 32/WIDTH.
  - STEP = WIDTH/8 bytes per beat.
  - imm = instr[15:0] zero-extended or truncated to WIDTH; imm<<2 is truncated to WIDTH.
- Fetch FSM: IDLE, FETCH, DONE.
  - IDLE -> FETCH on fetch_start: latch fetch_base = PC and beat = 0.
  - FETCH:
    - mem_req = 1 and adr = fetch_base + beat*STEP (mod 2^WIDTH).
    - On mem_ack, mem_rdata is written into instr slot beat. Beat 0 fills the MS bits [31:32-WIDTH] (big-endian); then beat increments.
    - On the ack of beat BEATS-1, go to DONE.
    - mem_req stays high, with adr stable, until ack.
  - DONE: instr_valid = 1 for exactly one cycle, then IDLE.
  - fetch_start is ignored outside IDLE.
  - A WIDTH=32 fetch takes one beat; minimum latency from fetch_start to instr_valid is BEATS+1 cycles with ack always high.
- Non-fetch memory access:
  - In IDLE/DONE: mem_req = data_req, adr = iord ? PC : aluout.
  - MDR loads mem_rdata on mem_ack only when the FSM is not in FETCH.
  - data_req asserted during FETCH is not forwarded and has no effect; the controller must wait for fetch_busy low.
- PC updates (PC <= nextpc mux) when pcen, in any FSM state. The in-flight fetch uses fetch_base and is unaffected.
- A and B load rd1/rd2 every cycle; aluout loads aluresult every cycle.
- Register file:
  - ra1 = instr[21+:REGBITS], ra2 = instr[16+:REGBITS].
  - wd = memtoreg ? aluout : MDR.
  - Synchronous write on regwrite.
  - Writes to register 0 are ignored; register 0 always reads 0.
  - Reads are combinational. A same-cycle write and read of the same register returns the old value, so A/B capture the pre-write value.
- ALU:
  - Width WIDTH; add/sub wrap modulo 2^WIDTH.
  - slt is a signed compare and yields 1 or 0.
  - Undefined alucontrol codes yield 0.
- Reset asserted mid-fetch: the fetch is aborted, instr cleared to 0, no instr_valid pulse, mem_req drops unless data_req is high.
- instr is held between fetches. Partially fetched bytes are visible during FETCH and are valid only after instr_valid.

Test Plan:
- WIDTH=8, PC=0x10, memory bytes 0x10..0x13 = 8C,22,00,04, ack always high; pulse fetch_start -> adr sequence 10,11,12,13, instr=0x8C220004, instr_valid pulses in cycle 5, fetch_busy low afterwards.
- WIDTH=8, ack withheld 3 cycles on beat 2 -> mem_req stays high with adr=0x12 stable; instr_valid delayed by 3 cycles; final instr unchanged.
- WIDTH=16, PC=0xFFFE -> beats at adr 0xFFFE then 0x0000 (wrap); instr = {word@FFFE, word@0000}.
- pcen with pcsource=00, alusrca=1, alusrcb=01 during FETCH (PC 0x10->0x14) -> fetch addresses still based on 0x10.
- Write 0x7F to r3 and attempt to write r0; slt r3 vs 0x80 at WIDTH=8 -> r0 reads 0; slt result 0 (0x7F > -128); sub 5-5 gives zero=1.
- Reset asserted after beat 1 of a fetch -> next cycle instr=0, FSM IDLE, no instr_valid, PC=0.

Source files
------------

// File: rtl/multicycle_datapath_p.sv
// Parametrised multicycle MIPS-subset datapath with an autonomous instruction-fetch
// sequencer. It assembles a 32-bit big-endian instruction from 32/WIDTH memory beats
// over a req/ack handshake, and steers the shared memory port between instruction
// fetch and controller-driven data accesses.
module multicycle_datapath_p #(
   parameter int WIDTH   = 8,
   parameter int REGBITS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch_start,
   input  logic             data_req,
   input  logic             alusrca,
   input  logic [1:0]       alusrcb,
   input  logic [2:0]       alucontrol,
   input  logic             iord,
   input  logic             memtoreg,
   input  logic             regdst,
   input  logic             regwrite,
   input  logic             pcen,
   input  logic [1:0]       pcsource,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic [WIDTH-1:0] adr,
   output logic [WIDTH-1:0] writedata,
   output logic [31:0]      instr,
   output logic             instr_valid,
   output logic             fetch_busy,
   output logic             zero
);

   localparam int BEATS = 32 / WIDTH;
   localparam int STEP  = WIDTH / 8;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int NREGS = 1 << REGBITS;

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t             state, state_next;
   logic [WIDTH-1:0]   pc, a, b, aluout, mdr, fetch_base;
   logic [CW-1:0]      beat;
   logic [31:0]        ir;
   logic [WIDTH-1:0]   rf [NREGS];
   logic [REGBITS-1:0] ra1, ra2, wa;
   logic [WIDTH-1:0]   rd1, rd2, wd;
   logic [WIDTH-1:0]   imm, imm_sh, jump_target;
   logic [WIDTH-1:0]   srca, srcb, aluresult, nextpc, fetch_adr;
   logic               last_beat;

   assign last_beat = (beat == CW'(BEATS - 1));
   assign fetch_adr = fetch_base + WIDTH'(beat) * WIDTH'(STEP);

   assign instr     = ir;
   assign writedata = b;
   assign zero      = (aluresult == '0);

   // Instruction field decode; immediates and jump target are zero-extended or truncated to WIDTH
   assign ra1         = ir[21 +: REGBITS];
   assign ra2         = ir[16 +: REGBITS];
   assign wa          = regdst ? ir[11 +: REGBITS] : ir[16 +: REGBITS];
   assign imm         = WIDTH'({16'h0000, ir[15:0]});
   assign imm_sh      = WIDTH'({14'h0000, ir[15:0], 2'b00});
   assign jump_target = WIDTH'({4'h0, ir[25:0], 2'b00});

   // Register 0 is hard-wired to zero on both read ports
   assign rd1 = (ra1 == '0) ? '0 : rf[ra1];
   assign rd2 = (ra2 == '0) ? '0 : rf[ra2];
   assign wd  = memtoreg ? aluout : mdr;

   // Fetch FSM state register
   always_ff @(posedge clk) begin
      // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Fetch FSM next-state logic
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_next = state;
      case (state)
         IDLE:    if (fetch_start)          state_next = FETCH;
         FETCH:   if (mem_ack && last_beat) state_next = DONE;
         DONE:                              state_next = IDLE;
         default:                           state_next = IDLE;
      endcase
   end

   // Fetch FSM outputs: the sequencer owns the memory port while in FETCH
   always_comb begin
      mem_req     = data_req;
      adr         = iord ? pc : aluout;
      instr_valid = 1'b0;
      fetch_busy  = 1'b1;
      case (state)
         IDLE:    fetch_busy = 1'b0;
         FETCH: begin
            mem_req = 1'b1;
            adr     = fetch_adr;
         end
         DONE:    instr_valid = 1'b1;
         default: fetch_busy = 1'b0;
      endcase
   end

   // Fetch sequencer: latch the base address, count beats, fill instr big-endian
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_base <= '0;
         beat       <= '0;
         ir         <= '0;
      end else if (state == IDLE && fetch_start) begin
         fetch_base <= pc;
         beat       <= '0;
      end else if (state == FETCH && mem_ack) begin
         for (int i = 0; i < BEATS; i++) begin
            if (beat == CW'(i)) ir[(BEATS-1-i)*WIDTH +: WIDTH] <= mem_rdata;
         end
         beat <= beat + CW'(1);
      end
   end

   // ALU operand selection
   always_comb begin
      srca = alusrca ? pc : a;
      case (alusrcb)
         2'b00:   srcb = b;
         2'b01:   srcb = WIDTH'(4);
         2'b10:   srcb = imm;
         default: srcb = imm_sh;
      endcase
   end

   // ALU: wrapping add/sub, signed set-less-than, undefined codes give zero
   always_comb begin
      aluresult = '0;
      case (alucontrol)
         3'b000:  aluresult = srca & srcb;
         3'b001:  aluresult = srca | srcb;
         3'b010:  aluresult = srca + srcb;
         3'b110:  aluresult = srca - srcb;
         3'b111:  aluresult[0] = ($signed(srca) < $signed(srcb));
         default: aluresult = '0;
      endcase
   end

   // Next-PC selection; pcsource 11 holds the current PC
   always_comb begin
      case (pcsource)
         2'b00:   nextpc = aluresult;
         2'b01:   nextpc = aluout;
         2'b10:   nextpc = jump_target;
         default: nextpc = pc;
      endcase
   end

   // Architectural datapath registers; MDR only captures data beats, never fetch beats
   always_ff @(posedge clk) begin
      if (reset) begin
         pc     <= '0;
         a      <= '0;
         b      <= '0;
         aluout <= '0;
         mdr    <= '0;
      end else begin
         a      <= rd1;
         b      <= rd2;
         aluout <= aluresult;
         if (pcen)                        pc  <= nextpc;
         if (mem_ack && state != FETCH) mdr <= mem_rdata;
      end
   end

   // Register file write port; writes to register 0 are discarded
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: this array is reset deliberately because every register must read 0 after reset;
         // that keeps it in flops rather than a RAM macro.
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else if (regwrite && wa != '0) begin
         rf[wa] <= wd;
      end
   end

endmodule

// File: tb/tb_multicycle_datapath_p.sv
// Directed self-checking bench for multicycle_datapath_p: a WIDTH=8 instance covers
// fetch timing, ack stalls, PC updates during fetch, register file, ALU table and
// mid-fetch reset; a WIDTH=16 instance covers the two-beat fetch with address wrap.
module tb_multicycle_datapath_p;

   logic        clk = 1'b0;
   logic        reset, fetch_start, data_req, alusrca, iord, memtoreg, regdst, regwrite, pcen, mem_ack;
   logic [1:0]  alusrcb, pcsource;
   logic [2:0]  alucontrol;

   logic [7:0]  rdata8, adr8, wdata8;
   logic        req8, valid8, busy8, zero8;
   logic [31:0] instr8;

   logic [15:0] rdata16, adr16, wdata16;
   logic        req16, valid16, busy16, zero16;
   logic [31:0] instr16;

   logic [7:0]  mem8 [256];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       a;
      logic [1:0] b;
      logic [2:0] op;
      logic [7:0] res;
      logic       z;
   } alu_vec_t;

   alu_vec_t vecs [12];

   always #5 clk = ~clk;

   assign rdata8  = mem8[adr8];
   assign rdata16 = (adr16 == 16'h0000) ? 16'h1234 :
                    (adr16 == 16'h0002) ? 16'hFFFE :
                    (adr16 == 16'hFFFE) ? 16'hABCD : 16'h0000;

   multicycle_datapath_p #(.WIDTH(8), .REGBITS(3)) u8 (
      .clk(clk), .reset(reset), .fetch_start(fetch_start), .data_req(data_req),
      .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol), .iord(iord),
      .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .pcen(pcen),
      .pcsource(pcsource), .mem_rdata(rdata8), .mem_ack(mem_ack), .mem_req(req8),
      .adr(adr8), .writedata(wdata8), .instr(instr8), .instr_valid(valid8),
      .fetch_busy(busy8), .zero(zero8)
   );

   multicycle_datapath_p #(.WIDTH(16), .REGBITS(3)) u16 (
      .clk(clk), .reset(reset), .fetch_start(fetch_start), .data_req(data_req),
      .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol), .iord(iord),
      .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .pcen(pcen),
      .pcsource(pcsource), .mem_rdata(rdata16), .mem_ack(mem_ack), .mem_req(req16),
      .adr(adr16), .writedata(wdata16), .instr(instr16), .instr_valid(valid16),
      .fetch_busy(busy16), .zero(zero16)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One 4-beat fetch on the 8-bit instance; optional ack stall on one beat and an
   // optional single PC update (controls preset by the caller) in the first FETCH cycle.
   task automatic fetch8(input logic [7:0] base, input int stall_beat, input int stalls,
                         input logic [31:0] exp_instr, input bit bump);
      int n;
      logic [7:0] ea;
      fetch_start = 1'b1;
      for (int bt = 0; bt < 4; bt++) begin
         n  = (bt == stall_beat) ? stalls : 0;
         ea = base + 8'(bt);
         for (int s = 0; s <= n; s++) begin
            @(negedge clk);
            fetch_start = 1'b0;
            pcen        = bump && (bt == 0) && (s == 0);
            check("fetch_adr", 32'(adr8), 32'(ea));
            check("fetch_req", 32'(req8), 32'd1);
            check("fetch_valid_early", 32'(valid8), 32'd0);
            mem_ack = (s == n);
         end
      end
      @(negedge clk);
      pcen    = 1'b0;
      mem_ack = 1'b1;
      check("fetch_valid", 32'(valid8), 32'd1);
      check("fetch_instr", instr8, exp_instr);
      @(negedge clk);
      check("valid_one_cycle", 32'(valid8), 32'd0);
      check("busy_after", 32'(busy8), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
      mem8[8'h10] = 8'h8C; mem8[8'h11] = 8'h22; mem8[8'h12] = 8'h00; mem8[8'h13] = 8'h04;
      mem8[8'h14] = 8'h00; mem8[8'h15] = 8'h60; mem8[8'h16] = 8'h18; mem8[8'h17] = 8'h80;
      mem8[8'h80] = 8'h7F; mem8[8'h81] = 8'h55;

      // ALU vectors with A=0x7F, B=0x00, PC=0x80, imm=0x80, imm<<2=0x00
      vecs[0]  = '{1'b1, 2'b01, 3'b111, 8'h01, 1'b0};  // slt -128 < 4
      vecs[1]  = '{1'b1, 2'b10, 3'b110, 8'h00, 1'b1};  // sub equal operands
      vecs[2]  = '{1'b0, 2'b10, 3'b111, 8'h00, 1'b1};  // slt 127 vs -128
      vecs[3]  = '{1'b1, 2'b10, 3'b010, 8'h00, 1'b1};  // add wraps
      vecs[4]  = '{1'b0, 2'b00, 3'b000, 8'h00, 1'b1};  // and
      vecs[5]  = '{1'b0, 2'b10, 3'b001, 8'hFF, 1'b0};  // or
      vecs[6]  = '{1'b1, 2'b01, 3'b010, 8'h84, 1'b0};  // PC + 4
      vecs[7]  = '{1'b0, 2'b01, 3'b110, 8'h7B, 1'b0};  // A - 4
      vecs[8]  = '{1'b0, 2'b10, 3'b011, 8'h00, 1'b1};  // undefined code
      vecs[9]  = '{1'b0, 2'b11, 3'b001, 8'h7F, 1'b0};  // imm<<2 truncates to 0
      vecs[10] = '{1'b1, 2'b00, 3'b111, 8'h01, 1'b0};  // slt -128 < 0
      vecs[11] = '{1'b0, 2'b01, 3'b001, 8'h7F, 1'b0};  // or with 4

      reset = 1'b1; fetch_start = 1'b0; data_req = 1'b0; alusrca = 1'b0; alusrcb = 2'b00;
      alucontrol = 3'b000; iord = 1'b0; memtoreg = 1'b0; regdst = 1'b0; regwrite = 1'b0;
      pcen = 1'b0; pcsource = 2'b00; mem_ack = 1'b1;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_instr", instr8, 32'h0);
      check("rst_valid", 32'(valid8), 32'd0);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_req", 32'(req8), 32'd0);
      check("rst_adr", 32'(adr8), 32'h0);
      check("rst_wdata", 32'(wdata8), 32'h0);
      check("rst_zero", 32'(zero8), 32'd1);
      check("rst_instr16", instr16, 32'h0);
      data_req = 1'b1;
      #1;
      check("rst_req_follows", 32'(req8), 32'd1);
      check("rst_req_follows16", 32'(req16), 32'd1);
      data_req = 1'b0;
      reset    = 1'b0;

      // WIDTH=16: fetch at 0, load PC=0xFFFE from imm, then fetch across the wrap
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      check("w16_busy", 32'(busy16), 32'd1);
      check("w16_req", 32'(req16), 32'd1);
      check("w16_adr0", 32'(adr16), 32'h0000);
      @(negedge clk);
      check("w16_adr1", 32'(adr16), 32'h0002);
      check("w16_valid_early", 32'(valid16), 32'd0);
      @(negedge clk);
      check("w16_valid", 32'(valid16), 32'd1);
      check("w16_instr", instr16, 32'h1234FFFE);
      pcen = 1'b1; pcsource = 2'b00; alusrca = 1'b0; alusrcb = 2'b10; alucontrol = 3'b010;
      @(negedge clk);
      pcen = 1'b0;
      check("w16_idle", 32'(busy16), 32'd0);
      iord = 1'b1;
      #1;
      check("w16_pc", 32'(adr16), 32'hFFFE);
      iord        = 1'b0;
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      check("w16_wrap_adr0", 32'(adr16), 32'hFFFE);
      @(negedge clk);
      check("w16_wrap_adr1", 32'(adr16), 32'h0000);
      @(negedge clk);
      check("w16_wrap_valid", 32'(valid16), 32'd1);
      check("w16_wrap_instr", instr16, 32'hABCD1234);

      // WIDTH=8: fresh reset, then PC 0 -> 0x10 by four PC+4 steps
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      pcen = 1'b1; pcsource = 2'b00; alusrca = 1'b1; alusrcb = 2'b01; alucontrol = 3'b010;
      repeat (4) @(negedge clk);
      pcen = 1'b0;
      iord = 1'b1;
      #1;
      check("pc_0x10", 32'(adr8), 32'h10);
      iord = 1'b0;

      fetch8(8'h10, -1, 0, 32'h8C220004, 1'b0);   // ack always high
      fetch8(8'h10, 2, 3, 32'h8C220004, 1'b0);    // ack withheld 3 cycles on beat 2
      fetch8(8'h10, -1, 0, 32'h8C220004, 1'b1);   // PC 0x10 -> 0x14 mid-fetch
      iord = 1'b1;
      #1;
      check("pc_bumped", 32'(adr8), 32'h14);
      iord = 1'b0;
      fetch8(8'h14, -1, 0, 32'h00601880, 1'b0);   // rs=3 rt=0 rd=3 imm=0x80

      // Load 0x7F from address 0x80 into r3, then try to write r0
      alusrca = 1'b0; alusrcb = 2'b10; alucontrol = 3'b010;
      #1;
      check("zero_nonzero", 32'(zero8), 32'd0);
      @(negedge clk);
      data_req = 1'b1;
      #1;
      check("load_req", 32'(req8), 32'd1);
      check("load_adr", 32'(adr8), 32'h80);
      @(negedge clk);
      data_req = 1'b0; regwrite = 1'b1; memtoreg = 1'b0; regdst = 1'b1;
      @(negedge clk);
      regdst = 1'b0; alusrcb = 2'b00; alucontrol = 3'b001;
      #1;
      check("a_prewrite", 32'(zero8), 32'd1);
      @(negedge clk);
      regwrite = 1'b0;
      #1;
      check("a_r3_written", 32'(zero8), 32'd0);
      @(negedge clk);
      check("r0_reads_zero", 32'(wdata8), 32'h0);

      // PC sources: hold, aluout, aluresult
      pcen = 1'b1; pcsource = 2'b11; alusrca = 1'b1; alusrcb = 2'b10; alucontrol = 3'b010; iord = 1'b1;
      #1;
      check("pc_before_hold", 32'(adr8), 32'h14);
      @(negedge clk);
      pcsource = 2'b01;
      check("pc_hold", 32'(adr8), 32'h14);
      @(negedge clk);
      check("pc_aluout", 32'(adr8), 32'h94);
      pcsource = 2'b00; alusrca = 1'b0; alusrcb = 2'b00; alucontrol = 3'b000;
      @(negedge clk);
      check("pc_aluresult", 32'(adr8), 32'h00);
      alusrca = 1'b1; alusrcb = 2'b10; alucontrol = 3'b010;
      @(negedge clk);
      pcen = 1'b0;
      check("pc_0x80", 32'(adr8), 32'h80);
      iord = 1'b0;

      // ALU table: zero checked combinationally, result seen as aluout on adr
      for (int i = 0; i < 12; i++) begin
         alusrca = vecs[i].a; alusrcb = vecs[i].b; alucontrol = vecs[i].op;
         #1;
         check($sformatf("alu_zero_%0d", i), 32'(zero8), 32'(vecs[i].z));
         @(negedge clk);
         check($sformatf("alu_res_%0d", i), 32'(adr8), 32'(vecs[i].res));
      end

      // Reset after beat 1 of a fetch at 0x80
      fetch_start = 1'b1; iord = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      check("abort_adr0", 32'(adr8), 32'h80);
      @(negedge clk);
      check("abort_adr1", 32'(adr8), 32'h81);
      @(negedge clk);
      check("abort_partial", instr8, 32'h7F551880);
      check("abort_adr2", 32'(adr8), 32'h82);
      reset = 1'b1; data_req = 1'b0;
      @(negedge clk);
      check("abort_instr", instr8, 32'h0);
      check("abort_busy", 32'(busy8), 32'd0);
      check("abort_valid", 32'(valid8), 32'd0);
      check("abort_req", 32'(req8), 32'd0);
      check("abort_pc", 32'(adr8), 32'h0);
      reset = 1'b0;
      @(negedge clk);
      check("abort_no_valid", 32'(valid8), 32'd0);
      check("abort_idle", 32'(busy8), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
